mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one synchronous single-port word RAM between two requesters of the core: instruction fetch (IF) and load/store (MEM).
- Sits between riscv_core and the SoC RAM. It replaces the current dual combinational ports with valid/ready request channels and fixed-latency response pulses.
- Arbitrates every cycle with MEM priority and an IF anti-starvation counter.
- Tracks the single in-flight response owner and supports pipeline flush of fetches.

Parameters:
- ADDR_W, 14, word-address width of RAM (RAM holds 2^ADDR_W 32-bit words).
- STARVE_MAX, 4, consecutive cycles IF may be denied before it wins priority once; range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req_valid  in  1  fetch request
- if_req_addr  in  32  fetch byte address
- if_req_ready  out  1  fetch granted this cycle (combinational)
- if_flush  in  1  cancel fetch response due this cycle and block fetch grant
- if_resp_valid  out  1  fetch data valid (1-cycle pulse)
- if_resp_data  out  32  fetch word
- if_resp_err  out  1  fetch address out of range
- mem_req_valid  in  1  data request
- mem_req_rw  in  1  0 read, 1 write
- mem_req_addr  in  32  data byte address
- mem_req_wdata  in  32  write data
- mem_req_wstrb  in  4  byte enables for writes
- mem_req_ready  out  1  data request granted (combinational)
- mem_resp_valid  out  1  read data or write ack (pulse)
- mem_resp_rdata  out  32  read word; 0 for write acks
- mem_resp_err  out  1  data address out of range
- ram_en  out  1  RAM access enable
- ram_we  out  4  RAM byte write enables
- ram_addr  out  ADDR_W  RAM word address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid one cycle after ram_en

Behaviour:
- Reset: rst and clk are as already decided (synchronous, active-high rst; clock clk). Registered state on reset: owner=NONE, err_q=0, starve_cnt=0. All resp_valid/err outputs are 0 in the cycle after reset; ram_en/ram_we are 0 while rst is high; ready outputs are 0 while rst is high.
- Grant logic, combinational each cycle:
  - MEM wins if mem_req_valid, unless starve_cnt==STARVE_MAX and if_req_valid and !if_flush, in which case IF wins.
  - Otherwise IF wins if if_req_valid and !if_flush.
  - At most one ready per cycle.
- Address decode:
  - word = addr[ADDR_W+1:2]; addr[1:0] ignored.
  - Out of range if addr[31:ADDR_W+2] != 0. The request is still granted, but ram_en=0 and the response carries err=1 with data 0.
- RAM drive on grant:
  - ram_en=1 (in range), ram_addr=word.
  - ram_we = mem_req_wstrb if MEM write, else 0.
  - ram_wdata = mem_req_wdata.
- Owner register, set at the grant edge: NONE / IF / MEM_RD / MEM_WR; an err bit is registered alongside.
- Latency: response exactly 1 cycle after grant. Back-to-back grants every cycle are allowed, so the path is fully pipelined with no bubbles.
- Response routing in the cycle after grant:
  - IF owner: if_resp_valid=!if_flush, if_resp_data = err ? 0 : ram_rdata.
  - MEM_RD: mem_resp_rdata = err ? 0 : ram_rdata.
  - MEM_WR: mem_resp_valid=1, mem_resp_rdata=0.
  - The inactive side's data outputs are 0.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, each cycle if_req_valid && !if_flush && !if_req_ready.
  - Clears when IF is granted or if_req_valid=0.
- if_flush in cycle N: suppresses the IF response in N and denies IF in N. MEM traffic is unaffected, and a MEM grant in N proceeds normally.
- Response channels have no backpressure; consumers must sample the pulse.
- Reset mid-operation: any pending response is discarded and no pulse is issued after reset.

Decomposition:
- Shared include common.v holds:
  - `DATA_BUS (existing);
  - new `MEM_ADDR_W default;
  - owner encoding `OWN_NONE/`OWN_IF/`OWN_MRD/`OWN_MWR (2 bits).
- One sub-module, mem_arb_pick: combinational grant selection plus the starve_cnt register. Inputs are the valids and if_flush; outputs are the two grants.

Test Plan:
- Single fetch if_req_addr=0x10, RAM word4=0xDEADBEEF -> if_req_ready=1 same cycle, ram_addr=4; next cycle if_resp_valid=1, data 0xDEADBEEF.
- Simultaneous IF and MEM read every cycle, STARVE_MAX=4 -> MEM granted 4 cycles, IF granted on the 5th, then the pattern repeats; no dropped or duplicated responses.
- MEM write addr=0x8, wdata=0x11223344, wstrb=4'b0010 -> ram_we=0010, mem_resp_valid pulse with rdata=0. A later read of 0x8 returns only byte1 changed (0x33 in bits 15:8).
- Fetch granted in cycle N, if_flush=1 in N+1 -> no if_resp_valid in N+1, and an IF request in N+1 is not granted.
- mem_req_addr=0x0010_0000 (out of range for ADDR_W=14) -> granted, ram_en=0; next cycle mem_resp_valid=1, mem_resp_err=1, rdata=0.
- Assert rst with a grant pending -> no response pulse afterward, starve_cnt=0, first post-reset fetch has 1-cycle latency.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the core-to-RAM arbiter: bus widths, default
// RAM size and the encoding of who owns the response slot.
package mem_arbiter_pkg;

    localparam int DATA_W     = 32;
    localparam int MEM_ADDR_W = 14;
    localparam int STARVE_W   = 4;

    // Owner of the single in-flight response, captured at the grant edge.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MRD  = 2'd2,
        OWN_MWR  = 2'd3
    } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between fetch and load/store. MEM normally wins; a
// fetch that has been denied STARVE_MAX consecutive eligible cycles wins
// once. Both grants are held low while rst is high.
module mem_arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req_valid_i,
    input  logic if_flush_i,
    input  logic mem_req_valid_i,
    output logic if_grant_o,
    output logic mem_grant_o
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                if_elig;
    logic                if_prio;

    // Pick the winner for this cycle; at most one grant is ever high.
    always_comb begin
        if_elig     = if_req_valid_i && !if_flush_i;
        if_prio     = if_elig && (starve_cnt_q == STARVE_LIM);
        mem_grant_o = !rst && mem_req_valid_i && !if_prio;
        if_grant_o  = !rst && if_elig && !mem_grant_o;
    end

    // Count consecutive denied fetch cycles; a flushed request holds the count.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (if_grant_o || !if_req_valid_i) begin
            starve_cnt_d = '0;
        end else if (if_elig && (starve_cnt_q != STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous single-port RAM between instruction fetch and
// load/store. Requests use valid/ready: a request transfers in the cycle
// where valid and ready are both high, ready is combinational and never
// waits on valid of the other side beyond priority. Responses are
// single-cycle pulses exactly one cycle after the grant, with no
// backpressure; a grant may be issued every cycle.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    input  logic [31:0]       if_req_addr,
    output logic              if_req_ready,
    input  logic              if_flush,
    output logic              if_resp_valid,
    output logic [DATA_W-1:0] if_resp_data,
    output logic              if_resp_err,
    input  logic              mem_req_valid,
    input  logic              mem_req_rw,
    input  logic [31:0]       mem_req_addr,
    input  logic [DATA_W-1:0] mem_req_wdata,
    input  logic [3:0]        mem_req_wstrb,
    output logic              mem_req_ready,
    output logic              mem_resp_valid,
    output logic [DATA_W-1:0] mem_resp_rdata,
    output logic              mem_resp_err,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    logic              if_grant, mem_grant, granted;
    logic              if_in_range, mem_in_range, sel_in_range;
    logic [ADDR_W-1:0] sel_word;
    owner_e            owner_q, owner_d;
    logic              err_q, err_d;
    logic              addr_lsb_unused;

    // Byte offsets are irrelevant to a word RAM.
    assign addr_lsb_unused = ^{if_req_addr[1:0], mem_req_addr[1:0]};

    mem_arb_pick #(
        .STARVE_MAX(STARVE_MAX)
    ) u_pick (
        .clk            (clk),
        .rst            (rst),
        .if_req_valid_i (if_req_valid),
        .if_flush_i     (if_flush),
        .mem_req_valid_i(mem_req_valid),
        .if_grant_o     (if_grant),
        .mem_grant_o    (mem_grant)
    );

    assign if_req_ready  = if_grant;
    assign mem_req_ready = mem_grant;

    // Decode the granted address, drive the RAM and decide the next owner.
    always_comb begin
        if_in_range  = (if_req_addr[31:ADDR_W+2] == '0);
        mem_in_range = (mem_req_addr[31:ADDR_W+2] == '0);
        granted      = if_grant || mem_grant;
        sel_in_range = mem_grant ? mem_in_range : if_in_range;
        sel_word     = mem_grant ? mem_req_addr[ADDR_W+1:2] : if_req_addr[ADDR_W+1:2];

        ram_en    = granted && sel_in_range;
        ram_addr  = sel_word;
        ram_we    = (mem_grant && mem_req_rw && mem_in_range) ? mem_req_wstrb : 4'b0000;
        ram_wdata = mem_req_wdata;

        owner_d = OWN_NONE;
        if (mem_grant) begin
            owner_d = mem_req_rw ? OWN_MWR : OWN_MRD;
        end else if (if_grant) begin
            owner_d = OWN_IF;
        end
        // An out-of-range access still completes, but answers with err and zero data.
        err_d = granted && !sel_in_range;
    end

    // Owner and error flag of the response due next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OWN_NONE;
            err_q   <= 1'b0;
        end else begin
            owner_q <= owner_d;
            err_q   <= err_d;
        end
    end

    // Route RAM read data to the owning side; a flush drops a fetch response.
    always_comb begin
        if_resp_valid  = 1'b0;
        if_resp_data   = '0;
        if_resp_err    = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        mem_resp_err   = 1'b0;
        if (!rst) begin
            case (owner_q)
                OWN_IF: begin
                    if (!if_flush) begin
                        if_resp_valid = 1'b1;
                        if_resp_err   = err_q;
                        if_resp_data  = err_q ? '0 : ram_rdata;
                    end
                end
                OWN_MRD: begin
                    mem_resp_valid = 1'b1;
                    mem_resp_err   = err_q;
                    mem_resp_rdata = err_q ? '0 : ram_rdata;
                end
                OWN_MWR: begin
                    mem_resp_valid = 1'b1;
                    mem_resp_err   = err_q;
                end
                default: ;
            endcase
        end
    end

endmodule
